decoder_38: RTL and testbench

- Registered 3-to-8 line decoder with 74HC138-style three-input enable and active-low one-cold outputs.
- Sits as a leaf in the lab datapath, driving chip-select or LED lines from a 3-bit code.
- A single registered output stage gives one-cycle latency and glitch-free outputs.

---
 rtl/decoder_38.sv | 50 +++++
 tb/tb_decoder_38.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_38.sv
// decoder_38: registered 3-to-8 line decoder with a 74HC138-style
// three-input enable group. Output polarity is selectable: one-cold
// (selected bit low) or one-hot (selected bit high). A single register
// stage gives one clock of latency and glitch-free outputs.
module decoder_38 #(
  parameter bit         ACTIVE_LOW = 1'b1,
  parameter logic [2:0] EN_PATTERN = 3'b100
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [2:0] data_i,
  input  logic [2:0] en_i,
  output logic [7:0] data_o,
  output logic       valid_o
);

  // Pattern driven while disabled or in reset: no line is selected.
  localparam logic [7:0] INACTIVE = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] one_hot;
  logic [7:0] data_d;
  logic [7:0] data_q;
  logic       valid_d;
  logic       valid_q;

  // Decode the select code and apply enable and output polarity.
  always_comb begin
    one_hot = 8'b0000_0001 << data_i;
    valid_d = (en_i == EN_PATTERN);
    data_d  = INACTIVE;
    if (valid_d) begin
      data_d = ACTIVE_LOW ? ~one_hot : one_hot;
    end
  end

  // Output register; reset forces the inactive pattern immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q  <= INACTIVE;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_decoder_38.sv
// tb_decoder_38: directed and randomized checks of decoder_38 in both
// the one-cold (default) and one-hot builds, driven in parallel.
module tb_decoder_38;

  logic       clk;
  logic       rst_n;
  logic [2:0] data;
  logic [2:0] en;
  logic [7:0] low_data;
  logic       low_valid;
  logic [7:0] hot_data;
  logic       hot_valid;

  int assertCount;
  int failCount;

  // Expected registered state from the reference model.
  logic [7:0] expLow;
  logic [7:0] expHot;
  logic       expValid;

  decoder_38 u_dut_low (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .data_i  (data),
    .en_i    (en),
    .data_o  (low_data),
    .valid_o (low_valid)
  );

  decoder_38 #(.ACTIVE_LOW(1'b0)) u_dut_hot (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .data_i  (data),
    .en_i    (en),
    .data_o  (hot_data),
    .valid_o (hot_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: line j is active iff enabled and j equals the code.
  function automatic logic [7:0] refDecode(input int code, input bit enabled, input bit activeLow);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) begin
      bit active;
      active = enabled && (j == code);
      r[j] = activeLow ? !active : active;
    end
    return r;
  endfunction

  function automatic int countActive(input logic [7:0] v, input bit activeLow);
    int n;
    n = 0;
    for (int j = 0; j < 8; j++) begin
      if (activeLow ? (v[j] == 1'b0) : (v[j] == 1'b1)) n++;
    end
    return n;
  endfunction

  task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, " low data"}, low_data, expLow);
    checkValue({tag, " low valid"}, {7'd0, low_valid}, {7'd0, expValid});
    checkValue({tag, " hot data"}, hot_data, expHot);
    checkValue({tag, " hot valid"}, {7'd0, hot_valid}, {7'd0, expValid});
  endtask

  // Drive inputs away from the edge, clock once, update the model.
  task automatic applyStimulus(input logic [2:0] d, input logic [2:0] e);
    @(negedge clk);
    data = d;
    en   = e;
    @(posedge clk);
    #1;
    expValid = (e == 3'b100);
    expLow   = refDecode(int'(d), expValid, 1'b1);
    expHot   = refDecode(int'(d), expValid, 1'b0);
  endtask

  task automatic modelReset();
    expValid = 1'b0;
    expLow   = 8'hFF;
    expHot   = 8'h00;
  endtask

  initial begin
    logic [7:0] sweep [8];
    logic [2:0] offPat [7];
    assertCount = 0;
    failCount   = 0;
    sweep  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    offPat = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b101};

    // Reset applied without any clock edge having loaded the flops.
    rst_n = 1'b1;
    data  = 3'b011;
    en    = 3'b100;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("reset async");

    // Reset held across edges with changing inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data = 3'($urandom);
      en   = 3'b100;
      @(posedge clk);
      #1;
      checkOutput("reset held");
    end

    // Release: first edge loads the decode of present inputs.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3'b011, 3'b100);
    checkOutput("reset release");
    checkValue("release literal", low_data, 8'hF7);

    // Full enabled sweep against the literal table.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(3'(k), 3'b100);
      checkOutput("sweep");
      checkValue("sweep literal", low_data, sweep[k]);
    end

    // Disable by G2B_n and re-enable.
    applyStimulus(3'b000, 3'b101);
    checkOutput("g2b disable");
    applyStimulus(3'b000, 3'b100);
    checkOutput("re-enable");
    checkValue("re-enable literal", low_data, 8'hFE);

    // Every non-matching enable pattern disables.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(3'b010, offPat[i]);
      checkOutput("disable pattern");
      checkValue("disable literal", low_data, 8'hFF);
    end
    applyStimulus(3'b010, 3'b100);
    checkValue("enable literal", low_data, 8'hFB);

    // Mid-cycle input change has no effect until the next edge.
    applyStimulus(3'b001, 3'b100);
    checkValue("pre-change", low_data, 8'hFD);
    #2;
    data = 3'b110;
    #1;
    checkOutput("mid-cycle hold");
    @(posedge clk);
    #1;
    expLow = refDecode(6, 1'b1, 1'b1);
    expHot = refDecode(6, 1'b1, 1'b0);
    checkOutput("mid-cycle sampled");
    checkValue("sampled literal", low_data, 8'hBF);

    // Reset pulse between edges, then recovery on the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("reset pulse");
    rst_n = 1'b1;
    #1;
    checkOutput("after pulse");
    @(posedge clk);
    #1;
    expValid = 1'b1;
    expLow   = refDecode(6, 1'b1, 1'b1);
    expHot   = refDecode(6, 1'b1, 1'b0);
    checkOutput("recovery");

    // One-hot build literal points.
    applyStimulus(3'b101, 3'b100);
    checkValue("hot enabled literal", hot_data, 8'h20);
    applyStimulus(3'b101, 3'b110);
    checkValue("hot disabled literal", hot_data, 8'h00);

    // Randomized traffic against the model, plus the one-active invariant.
    for (int i = 0; i < 60; i++) begin
      logic [2:0] e;
      e = ($urandom_range(1, 0) == 1) ? 3'b100 : 3'($urandom);
      applyStimulus(3'($urandom), e);
      checkOutput("random");
      checkValue("invariant", 8'(countActive(low_data, 1'b1)), expValid ? 8'd1 : 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
